core_sequencer: RTL
===================

Name: core_sequencer

Overview:
- Run-control and program-load controller for the 4-bit core.
- Loads the program PROM from a valid/ready word stream, holds the core in reset while loading, then releases it.
- Gates core execution through a clock enable: run, halt, single-step, PC breakpoint, cycle-count watchdog.
- Sits between the top-level test/debug interface and the core plus its PROM.

Parameters:
- PC_LEN, 7, width of the core PC and PROM address.
- INSTR_LEN, 8, PROM word width.
- RST_CYCLES, 2, cycles the core reset is held after START from IDLE (minimum 1).
- CNT_LEN, 16, width of the executed-cycle counter.
- MAX_CYCLES, 16'hFFFF, watchdog limit; 0 disables the watchdog.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- LOAD_REQ  in  1  pulse: enter LOAD (from IDLE or HALTED).
- START  in  1  pulse: start from IDLE, or resume from HALTED.
- HALT  in  1  pulse: stop execution.
- STEP  in  1  pulse: execute exactly one core cycle (HALTED only).
- LD_VALID  in  1  load word valid.
- LD_DATA  in  INSTR_LEN  load word.
- LD_LAST  in  1  marks the final word of the load.
- LD_READY  out  1  load word accepted when LD_VALID&LD_READY.
- PROM_WE  out  1  PROM write strobe.
- PROM_WADDR  out  PC_LEN  PROM write address.
- PROM_WDATA  out  INSTR_LEN  PROM write data.
- BP_EN  in  1  breakpoint enable.
- BP_ADDR  in  PC_LEN  breakpoint PC.
- PC  in  PC_LEN  core PC.
- CORE_RSTN  out  1  active-low reset to the core.
- CORE_CE  out  1  core clock enable.
- STATE  out  3  encoded FSM state.
- CYCLES  out  CNT_LEN  executed (enabled) core cycles since the last START from IDLE.
- TIMEOUT  out  1  sticky; watchdog fired.
- LOAD_OVF  out  1  sticky; load wrapped past the last address without LD_LAST.

Behaviour:
- Reset (RST=1 at a clock edge) has priority over everything. All outputs go to their reset values:
  - STATE=IDLE, CORE_RSTN=0, CORE_CE=0, LD_READY=0, PROM_WE=0, PROM_WADDR=0, PROM_WDATA=0.
  - CYCLES=0, TIMEOUT=0, LOAD_OVF=0.
  - Reset mid-load: PROM_WE is low in the cycle after RST.
- States: IDLE=0, LOAD=1, CRST=2, RUN=3, HALTED=4, STEP=5.
- Simultaneous command priority: HALT > STEP > START > LOAD_REQ. Commands that are illegal in the current state are ignored.
- IDLE:
  - CORE_RSTN=0, CE=0.
  - LOAD_REQ -> LOAD with the write pointer set to 0.
  - START -> CRST; clears CYCLES and TIMEOUT.
- LOAD:
  - CORE_RSTN=0, CE=0, LD_READY=1.
  - Handshake at edge t: PROM_WE=1 in cycle t+1, with PROM_WADDR = current pointer and PROM_WDATA = LD_DATA. The pointer then increments, wrapping mod 2^PC_LEN.
  - Handshake with LD_LAST -> IDLE; LD_READY=0 from t+1.
  - Accepting the word at address 2^PC_LEN-1 without LD_LAST sets LOAD_OVF and goes to IDLE.
  - HALT in LOAD aborts to IDLE; no write for a same-cycle handshake.
  - PROM_WE is never high for 2 consecutive cycles unless consecutive handshakes occur.
- CRST:
  - CORE_RSTN=0 for exactly RST_CYCLES cycles, then RUN. CORE_RSTN=1 from the first RUN cycle.
- RUN:
  - CORE_RSTN=1.
  - CORE_CE = 1, except forced 0 combinationally in the cycle where BP_EN && PC==BP_ADDR and the breakpoint is armed. The instruction at BP_ADDR does not execute.
  - A breakpoint hit -> HALTED.
  - CYCLES += 1 on every cycle with CE=1, saturating at all-ones.
  - HALT -> HALTED; CE=0 from the next cycle.
  - When CYCLES reaches MAX_CYCLES (MAX_CYCLES≠0): set TIMEOUT and go to HALTED.
- HALTED:
  - CORE_RSTN=1 (core state preserved), CE=0.
  - START -> RUN, with the breakpoint disarmed for that first RUN cycle so execution can pass BP_ADDR.
  - STEP -> STEP.
  - LOAD_REQ -> LOAD; the core goes back into reset.
- STEP:
  - CE=1 for exactly one cycle, regardless of breakpoint; CYCLES += 1; then HALTED.
- The breakpoint is re-armed after any cycle with CE=1.

Decomposition:
- Shared package/params file holds:
  - state encodings (IDLE..STEP) and the 3-bit STATE width;
  - CNT_LEN and watchdog defaults, added next to the existing DATA_LEN/PC_LEN/INSTR_LEN defines.
- One sub-module: core_seq_loader, which owns the LOAD handshake, write pointer, registered PROM write and LOAD_OVF.
- The FSM, CE/CORE_RSTN generation, breakpoint and counter stay in core_sequencer.

Test Plan:
- Load: LOAD_REQ, then 3 words 0x11,0x22,0x33 with LD_LAST on the third; LD_VALID gapped by 1 cycle -> PROM writes at addresses 0,1,2 with matching data, each one cycle after its handshake; STATE returns to IDLE; LOAD_OVF=0.
- Start: START from IDLE with RST_CYCLES=2 -> CORE_RSTN low exactly 2 cycles, then CE=1 and CYCLES counts 1,2,3.
- Breakpoint: BP_EN=1, BP_ADDR=5, PC increments from 0 -> CE=0 in the cycle PC=5 and STATE=HALTED. Then STEP -> exactly one CE pulse with PC=5. Then START -> runs past 5.
- Watchdog: MAX_CYCLES=10 -> TIMEOUT=1, STATE=HALTED, CYCLES=10, CE=0 thereafter.
- Priority and overflow:
  - HALT and STEP asserted together while HALTED -> no CE pulse.
  - Load of 128 words without LD_LAST -> LOAD_OVF=1 and IDLE after address 127.
- Reset mid-load: RST asserted after 2 handshakes -> PROM_WE=0 the next cycle, STATE=IDLE, all outputs at reset values.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared widths, defaults and FSM state encoding for the 4-bit core run-control block.
package core_sequencer_pkg;

    localparam int unsigned DATA_LEN_DEF   = 4;
    localparam int unsigned PC_LEN_DEF     = 7;
    localparam int unsigned INSTR_LEN_DEF  = 8;
    localparam int unsigned CNT_LEN_DEF    = 16;
    localparam int unsigned RST_CYCLES_DEF = 2;
    localparam int unsigned MAX_CYCLES_DEF = 32'h0000_FFFF;
    localparam int unsigned STATE_W        = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CRST   = 3'd2,
        ST_RUN    = 3'd3,
        ST_HALTED = 3'd4,
        ST_STEP   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/core_seq_loader.sv
// PROM load engine: valid/ready word intake, write pointer, registered PROM write, overflow flag.
module core_seq_loader
    import core_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = PC_LEN_DEF,
    parameter int unsigned DATA_W = INSTR_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              abort,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              load_done,
    output logic              prom_we,
    output logic [ADDR_W-1:0] prom_waddr,
    output logic [DATA_W-1:0] prom_wdata,
    output logic              load_ovf
);

    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ovf_q, ovf_d;
    logic              accept;
    logic              ptr_at_end;

    always_comb begin
        accept     = ready_q && ld_valid && !abort;
        ptr_at_end = (ptr_q == '1);
        ready_d    = ready_q;
        we_d       = 1'b0;
        ptr_d      = ptr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        ovf_d      = ovf_q;
        load_done  = 1'b0;
        if (load_start) begin
            ready_d = 1'b1;
            ptr_d   = '0;
        end else if (abort) begin
            ready_d = 1'b0;
        end else if (accept) begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = ld_data;
            ptr_d   = ptr_q + 1'b1;
            // The top address ends the load even without LD_LAST; that case is flagged.
            if (ld_last || ptr_at_end) begin
                ready_d   = 1'b0;
                load_done = 1'b1;
            end
            if (ptr_at_end && !ld_last) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            ptr_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ready_q <= ready_d;
            we_q    <= we_d;
            ptr_q   <= ptr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ld_ready   = ready_q;
    assign prom_we    = we_q;
    assign prom_waddr = waddr_q;
    assign prom_wdata = wdata_q;
    assign load_ovf   = ovf_q;

endmodule

// File: rtl/core_sequencer.sv
// Run-control sequencer: program load, core reset hold, run/halt/step, breakpoint and watchdog.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned        PC_LEN     = PC_LEN_DEF,
    parameter int unsigned        INSTR_LEN  = INSTR_LEN_DEF,
    parameter int unsigned        RST_CYCLES = RST_CYCLES_DEF,
    parameter int unsigned        CNT_LEN    = CNT_LEN_DEF,
    parameter logic [CNT_LEN-1:0] MAX_CYCLES = CNT_LEN'(MAX_CYCLES_DEF)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 LOAD_REQ,
    input  logic                 START,
    input  logic                 HALT,
    input  logic                 STEP,
    input  logic                 LD_VALID,
    input  logic [INSTR_LEN-1:0] LD_DATA,
    input  logic                 LD_LAST,
    output logic                 LD_READY,
    output logic                 PROM_WE,
    output logic [PC_LEN-1:0]    PROM_WADDR,
    output logic [INSTR_LEN-1:0] PROM_WDATA,
    input  logic                 BP_EN,
    input  logic [PC_LEN-1:0]    BP_ADDR,
    input  logic [PC_LEN-1:0]    PC,
    output logic                 CORE_RSTN,
    output logic                 CORE_CE,
    output logic [2:0]           STATE,
    output logic [CNT_LEN-1:0]   CYCLES,
    output logic                 TIMEOUT,
    output logic                 LOAD_OVF
);

    localparam int unsigned RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_e         state_q, state_d;
    logic               core_rstn_q, core_rstn_d;
    logic               ce_en_q, ce_en_d;
    logic               bp_armed_q, bp_armed_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
    logic [CNT_LEN-1:0] cycles_q, cycles_d;
    logic               timeout_q, timeout_d;
    logic               bp_hit, core_ce, wd_fire;
    logic               load_start, load_abort, load_done;

    always_comb begin
        bp_hit  = bp_armed_q && BP_EN && (PC == BP_ADDR);
        // ce_en_q is the registered enable; only a RUN-state breakpoint can veto it in-cycle.
        core_ce = ce_en_q && !((state_q == ST_RUN) && bp_hit);
        wd_fire = (MAX_CYCLES != '0) && (state_q == ST_RUN) && core_ce &&
                  ((cycles_q + 1'b1) == MAX_CYCLES);

        state_d    = state_q;
        rcnt_d     = rcnt_q;
        cycles_d   = cycles_q;
        timeout_d  = timeout_q;
        bp_armed_d = bp_armed_q || core_ce;
        load_start = 1'b0;
        load_abort = 1'b0;

        if (core_ce && (cycles_q != '1)) begin
            cycles_d = cycles_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d    = ST_CRST;
                    rcnt_d     = RCNT_W'(RST_CYCLES - 1);
                    cycles_d   = '0;
                    timeout_d  = 1'b0;
                    bp_armed_d = 1'b1;
                end else if (LOAD_REQ) begin
                    state_d    = ST_LOAD;
                    load_start = 1'b1;
                end
            end
            ST_LOAD: begin
                if (HALT) begin
                    state_d    = ST_IDLE;
                    load_abort = 1'b1;
                end else if (load_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CRST: begin
                if (rcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (HALT || bp_hit || wd_fire) begin
                    state_d = ST_HALTED;
                end
                if (wd_fire) begin
                    timeout_d = 1'b1;
                end
            end
            ST_HALTED: begin
                // HALT outranks the other commands here, so it simply keeps the core parked.
                if (!HALT) begin
                    if (STEP) begin
                        state_d = ST_STEP;
                    end else if (START) begin
                        state_d    = ST_RUN;
                        bp_armed_d = 1'b0;
                    end else if (LOAD_REQ) begin
                        state_d    = ST_LOAD;
                        load_start = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        core_rstn_d = (state_d == ST_RUN) || (state_d == ST_HALTED) || (state_d == ST_STEP);
        ce_en_d     = (state_d == ST_RUN) || (state_d == ST_STEP);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            core_rstn_q <= 1'b0;
            ce_en_q     <= 1'b0;
            bp_armed_q  <= 1'b1;
            rcnt_q      <= '0;
            cycles_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            core_rstn_q <= core_rstn_d;
            ce_en_q     <= ce_en_d;
            bp_armed_q  <= bp_armed_d;
            rcnt_q      <= rcnt_d;
            cycles_q    <= cycles_d;
            timeout_q   <= timeout_d;
        end
    end

    core_seq_loader #(
        .ADDR_W (PC_LEN),
        .DATA_W (INSTR_LEN)
    ) u_loader (
        .clk        (CLK),
        .rst        (RST),
        .load_start (load_start),
        .abort      (load_abort),
        .ld_valid   (LD_VALID),
        .ld_data    (LD_DATA),
        .ld_last    (LD_LAST),
        .ld_ready   (LD_READY),
        .load_done  (load_done),
        .prom_we    (PROM_WE),
        .prom_waddr (PROM_WADDR),
        .prom_wdata (PROM_WDATA),
        .load_ovf   (LOAD_OVF)
    );

    assign STATE     = state_q;
    assign CORE_RSTN = core_rstn_q;
    assign CORE_CE   = core_ce;
    assign CYCLES    = cycles_q;
    assign TIMEOUT   = timeout_q;

endmodule
